// File: rtl/dpc_mem_pkg.sv
// Shared definitions for the RAM bus initiator: FSM encoding, default widths
// and the wait-state counter width.
package dpc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } mem_state_e;

    localparam int unsigned DEF_ADDRESS_SIZE = 16;
    localparam int unsigned DEF_DATA_SIZE    = 8;
    localparam int unsigned WAIT_CNT_W       = 4;

endpackage

// File: rtl/ram_data_pad.sv
// Tri-state driver for the shared RAM data bus; the only place a 'z is
// produced, so the controlling FSM stays purely two-state.
module ram_data_pad
    import dpc_mem_pkg::*;
#(
    parameter int DataSize = DEF_DATA_SIZE
) (
    input  logic                En,
    input  logic [DataSize-1:0] DOut,
    output logic [DataSize-1:0] DIn,
    inout  wire  [DataSize-1:0] Data
);

    assign Data = En ? DOut : {DataSize{1'bz}};
    assign DIn  = Data;

endmodule

// File: rtl/ram_master.sv
// Bus initiator for one RAM: single read/write requests in, registered
// Address/CS/WE_n and tri-state Data out, with wait states and read turnaround.
module ram_master
    import dpc_mem_pkg::*;
#(
    parameter int AddressSize = DEF_ADDRESS_SIZE,
    parameter int DataSize    = DEF_DATA_SIZE,
    parameter int WaitStates  = 0
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    // Request port: a request transfers on a rising edge where ReqValid and
    // ReqReady are both high. The requester holds ReqWE/ReqAddr/ReqWData
    // stable until then; anything presented while ReqReady is low is ignored.
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqWE,
    input  logic [AddressSize-1:0] ReqAddr,
    input  logic [DataSize-1:0]    ReqWData,
    output logic                   RspValid,
    output logic [DataSize-1:0]    RspRData,
    output logic [AddressSize-1:0] Address,
    inout  wire  [DataSize-1:0]    Data,
    output logic                   CS,
    output logic                   WE_n,
    output mem_state_e             dbg_state
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WaitStates);

    mem_state_e            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  drive_en;
    logic [DataSize-1:0]   wdata_q;
    logic [DataSize-1:0]   data_in;

    // drive_en doubles as the latched write flag for the whole access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            drive_en <= 1'b0;
            wdata_q  <= '0;
            Address  <= '0;
            CS       <= 1'b0;
            WE_n     <= 1'b1;
            RspValid <= 1'b0;
            RspRData <= '0;
        end else begin
            RspValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        state    <= ST_ACCESS;
                        Address  <= ReqAddr;
                        WE_n     <= ~ReqWE;
                        drive_en <= ReqWE;
                        wdata_q  <= ReqWData;
                        CS       <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        CS       <= 1'b0;
                        WE_n     <= 1'b1;
                        drive_en <= 1'b0;
                        if (drive_en) begin
                            state <= ST_IDLE;
                        end else begin
                            // RAM read path has settled since Address last moved.
                            RspRData <= data_in;
                            RspValid <= 1'b1;
                            state    <= ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady  = (state == ST_IDLE);
    assign dbg_state = state;

    ram_data_pad #(
        .DataSize (DataSize)
    ) u_pad (
        .En   (drive_en),
        .DOut (wdata_q),
        .DIn  (data_in),
        .Data (Data)
    );

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: two instances (0 and 3 wait states), each with a
// behavioural RAM responder, checked against a bench-side memory/timing model.
`timescale 1ns/1ps
module tb_ram_master;
    import dpc_mem_pkg::*;

    localparam int W0 = 0;
    localparam int W3 = 3;

    // ---------------- clock / reset ----------------
    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- DUT 0 (WaitStates = 0) ----------------
    logic        req_valid0 = 1'b0;
    logic        req_we0    = 1'b0;
    logic [15:0] req_addr0  = '0;
    logic [7:0]  req_wdata0 = '0;
    logic        req_ready0, rsp_valid0, cs0, we_n0;
    logic [7:0]  rsp_rdata0;
    logic [15:0] address0;
    wire  [7:0]  data0;
    mem_state_e  st0;

    ram_master #(.AddressSize(16), .DataSize(8), .WaitStates(W0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(req_valid0), .ReqReady(req_ready0), .ReqWE(req_we0),
        .ReqAddr(req_addr0), .ReqWData(req_wdata0),
        .RspValid(rsp_valid0), .RspRData(rsp_rdata0),
        .Address(address0), .Data(data0), .CS(cs0), .WE_n(we_n0),
        .dbg_state(st0)
    );

    // ---------------- DUT 3 (WaitStates = 3) ----------------
    logic        req_valid3 = 1'b0;
    logic        req_we3    = 1'b0;
    logic [15:0] req_addr3  = '0;
    logic [7:0]  req_wdata3 = '0;
    logic        req_ready3, rsp_valid3, cs3, we_n3;
    logic [7:0]  rsp_rdata3;
    logic [15:0] address3;
    wire  [7:0]  data3;
    mem_state_e  st3;

    ram_master #(.AddressSize(16), .DataSize(8), .WaitStates(W3)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(req_valid3), .ReqReady(req_ready3), .ReqWE(req_we3),
        .ReqAddr(req_addr3), .ReqWData(req_wdata3),
        .RspValid(rsp_valid3), .RspRData(rsp_rdata3),
        .Address(address3), .Data(data3), .CS(cs3), .WE_n(we_n3),
        .dbg_state(st3)
    );

    // ---------------- RAM responders ----------------
    logic [7:0] mem0 [65536];
    logic [7:0] mem3 [65536];

    assign data0 = (cs0 && we_n0) ? mem0[address0] : 8'hzz;
    assign data3 = (cs3 && we_n3) ? mem3[address3] : 8'hzz;

    always @(posedge Clk) begin
        if (cs0 && !we_n0) mem0[address0] <= data0;
        if (cs3 && !we_n3) mem3[address3] <= data3;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got3_q[$];

    // Per-cycle history sampled mid-cycle, indexed by cycle number.
    bit         h_cs0 [4096];
    bit         h_rv0 [4096];
    logic [7:0] h_d0  [4096];
    bit         h_cs3 [4096];
    bit         h_rv3 [4096];

    always @(negedge Clk) begin
        h_cs0[cyc & 4095] = cs0;
        h_rv0[cyc & 4095] = rsp_valid0;
        h_d0[cyc & 4095]  = data0;
        h_cs3[cyc & 4095] = cs3;
        h_rv3[cyc & 4095] = rsp_valid3;
        if (rsp_valid0) got_q.push_back(rsp_rdata0);
        if (rsp_valid3) got3_q.push_back(rsp_rdata3);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    // Presents a request and returns k, the edge that accepts it. Leaves
    // ReqValid asserted so consecutive calls form a held back-to-back stream.
    task automatic issue(input bit sel, input bit we, input logic [15:0] a,
                         input logic [7:0] d, output int k);
        bit got;
        got = 1'b0;
        k   = -1;
        if (sel) begin
            req_valid3 = 1'b1; req_we3 = we; req_addr3 = a; req_wdata3 = d;
        end else begin
            req_valid0 = 1'b1; req_we0 = we; req_addr0 = a; req_wdata0 = d;
        end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge Clk);
            if ((sel ? req_ready3 : req_ready0) === 1'b1) begin
                got = 1'b1;
                k   = cyc + 1;
            end
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_timeout: dut%0d ReqReady stayed 0 for 50 cycles, need 1", sel ? 3 : 0);
        end else begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        tests_run++; if (cs0 !== 1'b0) begin tests_failed++; $display("FAIL reset_cs: got %b need 0", cs0); end
        tests_run++; if (we_n0 !== 1'b1) begin tests_failed++; $display("FAIL reset_we_n: got %b need 1", we_n0); end
        tests_run++; if (address0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h need 0000", address0); end
        tests_run++; if (rsp_valid0 !== 1'b0) begin tests_failed++; $display("FAIL reset_rspvalid: got %b need 0", rsp_valid0); end
        tests_run++; if (rsp_rdata0 !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata: got %h need 00", rsp_rdata0); end
        tests_run++; if (st0 !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d need %0d", st0, ST_IDLE); end
        tests_run++; if (cs3 !== 1'b0) begin tests_failed++; $display("FAIL reset_cs3: got %b need 0", cs3); end
        Rst_n = 1'b1;
        @(negedge Clk);
        tests_run++; if (req_ready0 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready0: got %b need 1", req_ready0); end
        tests_run++; if (req_ready3 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready3: got %b need 1", req_ready3); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_write_read();
        int kw, kr, n;
        issue(1'b0, 1'b1, 16'h0010, 8'hA5, kw);
        ref_mem[16'h0010] = 8'hA5;
        exp_q.delete(); got_q.delete();
        issue(1'b0, 1'b0, 16'h0010, 8'h00, kr);
        exp_q.push_back(ref_mem[16'h0010]);
        idle(5);
        tests_run++; if (kr - kw != W0 + 2) begin tests_failed++; $display("FAIL wr_spacing: got %0d need %0d", kr - kw, W0 + 2); end
        tests_run++; if (h_cs0[kr & 4095] !== 1'b1) begin tests_failed++; $display("FAIL wr_cs_high: got %b need 1", h_cs0[kr & 4095]); end
        tests_run++; if (h_rv0[(kr + W0 + 1) & 4095] !== 1'b1) begin tests_failed++; $display("FAIL wr_rsp_cycle: got %b need 1", h_rv0[(kr + W0 + 1) & 4095]); end
        n = 0;
        for (int c = kr; c <= kr + 4; c++) n += int'(h_rv0[c & 4095]);
        tests_run++; if (n != 1) begin tests_failed++; $display("FAIL wr_rsp_pulses: got %0d need 1", n); end
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++; $display("FAIL wr_rsp_count: got %0d need 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            tests_failed++; $display("FAIL wr_rdata: got %h need %h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_read_then_write();
        int kw0, kr, kw;
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        issue(1'b0, 1'b1, 16'h0001, d1, kw0);
        ref_mem[16'h0001] = d1;
        exp_q.delete(); got_q.delete();
        issue(1'b0, 1'b0, 16'h0001, 8'hC3, kr);
        exp_q.push_back(ref_mem[16'h0001]);
        issue(1'b0, 1'b1, 16'h0002, d2, kw);
        ref_mem[16'h0002] = d2;
        idle(3);
        tests_run++; if (kw - kr != W0 + 3) begin tests_failed++; $display("FAIL rw_turnaround: got %0d need %0d", kw - kr, W0 + 3); end
        tests_run++; if (h_d0[(kr + 1) & 4095] === 8'hC3) begin tests_failed++; $display("FAIL rw_bus_released: got %h need undriven", h_d0[(kr + 1) & 4095]); end
        tests_run++; if (h_cs0[(kr + 1) & 4095] !== 1'b0) begin tests_failed++; $display("FAIL rw_cs_low: got %b need 0", h_cs0[(kr + 1) & 4095]); end
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++; $display("FAIL rw_rsp_count: got %0d need 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            tests_failed++; $display("FAIL rw_rdata: got %h need %h", got_q[0], exp_q[0]);
        end
        tests_run++; if (mem0[16'h0002] !== ref_mem[16'h0002]) begin tests_failed++; $display("FAIL rw_write: got %h need %h", mem0[16'h0002], ref_mem[16'h0002]); end
    endtask

    task automatic test_wait_states();
        int kw, kr, n_cs, n_rv;
        got3_q.delete();
        issue(1'b1, 1'b1, 16'hFFFF, 8'h3C, kw);
        issue(1'b1, 1'b0, 16'hFFFF, 8'h00, kr);
        idle(8);
        n_cs = 0;
        n_rv = 0;
        for (int c = kr - 1; c <= kr + 6; c++) n_cs += int'(h_cs3[c & 4095]);
        for (int c = kr; c <= kr + 7; c++) n_rv += int'(h_rv3[c & 4095]);
        tests_run++; if (kr - kw != W3 + 2) begin tests_failed++; $display("FAIL ws_write_spacing: got %0d need %0d", kr - kw, W3 + 2); end
        tests_run++; if (n_cs != W3 + 1) begin tests_failed++; $display("FAIL ws_cs_cycles: got %0d need %0d", n_cs, W3 + 1); end
        tests_run++; if (h_cs3[kr & 4095] !== 1'b1) begin tests_failed++; $display("FAIL ws_cs_start: got %b need 1", h_cs3[kr & 4095]); end
        tests_run++; if (h_rv3[(kr + W3 + 1) & 4095] !== 1'b1) begin tests_failed++; $display("FAIL ws_rsp_cycle: got %b need 1", h_rv3[(kr + W3 + 1) & 4095]); end
        tests_run++; if (n_rv != 1) begin tests_failed++; $display("FAIL ws_rsp_pulses: got %0d need 1", n_rv); end
        tests_run++;
        if (got3_q.size() != 1) begin
            tests_failed++; $display("FAIL ws_rsp_count: got %0d need 1", got3_q.size());
        end else if (got3_q[0] !== 8'h3C) begin
            tests_failed++; $display("FAIL ws_rdata: got %h need 3c", got3_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4];
        logic [7:0]  d [4];
        int          k [4];
        int          kt;
        logic [15:0] base;
        base = 16'($urandom_range(16'h8000, 16'h8FF0));
        for (int i = 0; i < 4; i++) begin
            a[i] = base + 16'(i * 3);
            d[i] = 8'($urandom);
            issue(1'b0, 1'b1, a[i], d[i], kt);
            k[i] = kt;
            ref_mem[a[i]] = d[i];
        end
        idle(2);
        for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (k[i] - k[i-1] != W0 + 2) begin tests_failed++; $display("FAIL b2b_spacing[%0d]: got %0d need %0d", i, k[i] - k[i-1], W0 + 2); end
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem0[a[i]] !== ref_mem[a[i]]) begin tests_failed++; $display("FAIL b2b_ram[%0d]: addr %h got %h need %h", i, a[i], mem0[a[i]], ref_mem[a[i]]); end
        end
    endtask

    task automatic test_hold_while_busy();
        logic [15:0] r, j1, j2, x;
        logic [7:0]  dr, dx, s1, s2;
        int          kw0, kr, kx;
        r  = 16'h9000 + 16'($urandom_range(0, 255));
        j1 = 16'hA000 + 16'($urandom_range(0, 255));
        j2 = 16'hB000 + 16'($urandom_range(0, 255));
        x  = 16'hC000 + 16'($urandom_range(0, 255));
        dr = 8'($urandom);
        dx = 8'($urandom);
        s1 = mem0[j1];
        s2 = mem0[j2];
        issue(1'b0, 1'b1, r, dr, kw0);
        ref_mem[r] = dr;
        exp_q.delete(); got_q.delete();
        issue(1'b0, 1'b0, r, 8'h00, kr);
        exp_q.push_back(ref_mem[r]);
        // Busy: present junk requests that must be ignored.
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = j1; req_wdata0 = ~s1;
        @(negedge Clk);
        tests_run++; if (address0 !== r) begin tests_failed++; $display("FAIL hold_addr_access: got %h need %h", address0, r); end
        @(posedge Clk); #1;
        req_valid0 = 1'b0; req_addr0 = j2; req_wdata0 = ~s2;
        @(negedge Clk);
        tests_run++; if (address0 !== r) begin tests_failed++; $display("FAIL hold_addr_turn: got %h need %h", address0, r); end
        @(posedge Clk); #1;
        issue(1'b0, 1'b1, x, dx, kx);
        ref_mem[x] = dx;
        idle(3);
        tests_run++; if (kx - kr != W0 + 3) begin tests_failed++; $display("FAIL hold_accept: got %0d need %0d", kx - kr, W0 + 3); end
        tests_run++; if (mem0[x] !== ref_mem[x]) begin tests_failed++; $display("FAIL hold_write: got %h need %h", mem0[x], ref_mem[x]); end
        tests_run++; if (mem0[j1] !== s1) begin tests_failed++; $display("FAIL hold_junk1: got %h need %h", mem0[j1], s1); end
        tests_run++; if (mem0[j2] !== s2) begin tests_failed++; $display("FAIL hold_junk2: got %h need %h", mem0[j2], s2); end
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++; $display("FAIL hold_rsp_count: got %0d need 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            tests_failed++; $display("FAIL hold_rdata: got %h need %h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] base, a;
        logic [7:0]  d, e;
        bit          we, prev_rd;
        int          k, kprev;
        base = 16'($urandom_range(16'h0100, 16'h7F00));
        exp_q.delete(); got_q.delete();
        kprev   = -1;
        prev_rd = 1'b0;
        for (int i = 0; i < 32; i++) begin
            we = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            a  = base + 16'((i < 8) ? i : int'($urandom_range(0, 7)));
            d  = 8'($urandom);
            issue(1'b0, we, a, d, k);
            if (we) ref_mem[a] = d;
            else    exp_q.push_back(ref_mem[a]);
            if (kprev >= 0) begin
                tests_run++;
                if (k - kprev != (prev_rd ? W0 + 3 : W0 + 2)) begin
                    tests_failed++;
                    $display("FAIL rnd_spacing[%0d]: got %0d need %0d", i, k - kprev, prev_rd ? W0 + 3 : W0 + 2);
                end
            end
            kprev   = k;
            prev_rd = !we;
        end
        idle(5);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rnd_rsp_count: got %0d need %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            d = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (d !== e) begin tests_failed++; $display("FAIL rnd_rdata: got %h need %h", d, e); end
        end
    endtask

    task automatic test_reset_mid_access();
        int kr, n;
        got_q.delete();
        issue(1'b0, 1'b0, 16'h0010, 8'h96, kr);
        Rst_n = 1'b0;
        #1;
        tests_run++; if (cs0 !== 1'b0) begin tests_failed++; $display("FAIL abort_cs: got %b need 0", cs0); end
        tests_run++; if (we_n0 !== 1'b1) begin tests_failed++; $display("FAIL abort_we_n: got %b need 1", we_n0); end
        tests_run++; if (data0 === 8'h96) begin tests_failed++; $display("FAIL abort_bus_released: got %h need undriven", data0); end
        tests_run++; if (address0 !== 16'h0000) begin tests_failed++; $display("FAIL abort_addr: got %h need 0000", address0); end
        req_valid0 = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        @(negedge Clk);
        tests_run++; if (req_ready0 !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b need 1", req_ready0); end
        idle(3);
        n = 0;
        for (int c = kr; c < cyc; c++) n += int'(h_rv0[c & 4095]);
        tests_run++; if (n != 0) begin tests_failed++; $display("FAIL abort_no_rsp: got %0d pulses need 0", n); end
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL abort_rsp_q: got %0d need 0", got_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_read_then_write();
        test_wait_states();
        test_back_to_back();
        test_hold_while_busy();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
